// File: rtl/matmul_apb_master.sv
// Purpose : single-outstanding APB4 master bridging a valid/ready command stream to the
//           matrix-multiplier APB slave, with a bounded PREADY wait and write hold-off on busy.
// Latency : handshake at edge E -> SETUP after E, ACCESS after E+1, response after E+2+waits.
// Backpr. : one transfer in flight; cmd_ready_o low outside IDLE and for writes while busy_i;
//           the response is held until rsp_ready_i.
// Ports   : clk_i/rst_i (sync, active-high); cmd_* command stream in; rsp_* response stream out;
//           psel_o/penable_o/pwrite_o/paddr_o/pwdata_o/pstrb_o/pready_i/pslverr_i/prdata_i APB4;
//           busy_i accelerator busy flag (gates write commands only).
module matmul_apb_master #(
    parameter  int BUS_WIDTH  = 32,
    parameter  int DATA_WIDTH = 8,
    parameter  int ADDR_WIDTH = 16,
    parameter  int TIMEOUT    = 255,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
    input  logic [MAX_DIM-1:0]    cmd_strb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [MAX_DIM-1:0]    pstrb_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i,
    input  logic                  busy_i
);

    // A zero TIMEOUT still needs a legal 1-bit counter even though it is never used.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [BUS_WIDTH-1:0]    pwdata_q, pwdata_d;
    logic [MAX_DIM-1:0]      pstrb_q, pstrb_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [BUS_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    cmd_fire;
    logic                    abort;

    // Reads stay accepted while busy so status can be polled mid-computation.
    assign cmd_ready_o = (state_q == IDLE) && !rst_i && !(busy_i && cmd_write_i);
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign abort       = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write_i;
                    paddr_d   = cmd_addr_i;
                    // Reads drive no data and no lanes on the bus.
                    pwdata_d  = cmd_write_i ? cmd_wdata_i : '0;
                    pstrb_d   = cmd_write_i ? cmd_strb_i  : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                // A completing slave beats the abort when both land on the same edge.
                if (pready_i) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
                    rsp_err_d     = pslverr_i;
                    rsp_timeout_d = 1'b0;
                end else if (abort) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (TIMEOUT != 0) begin
                    // Aborting at TIMEOUT-1 keeps the counter from ever wrapping.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Purpose : directed bench for matmul_apb_master: vector table of APB transfers plus
//           hand-written timeout, busy hold-off and mid-transfer reset sequences.
// Ports   : drives every DUT port; TIMEOUT set to 4 so the abort path is reachable.
module tb_matmul_apb_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [15:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_strb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [15:0] paddr_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i;
    logic        pslverr_i;
    logic [31:0] prdata_i;
    logic        busy_i;

    int errors = 0;
    int checks = 0;

    matmul_apb_master #(
        .BUS_WIDTH (32),
        .DATA_WIDTH(8),
        .ADDR_WIDTH(16),
        .TIMEOUT   (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_write_i  (cmd_write_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .cmd_strb_i   (cmd_strb_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .pwrite_o     (pwrite_o),
        .paddr_o      (paddr_o),
        .pwdata_o     (pwdata_o),
        .pstrb_o      (pstrb_o),
        .pready_i     (pready_i),
        .pslverr_i    (pslverr_i),
        .prdata_i     (prdata_i),
        .busy_i       (busy_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;     // ACCESS cycles with pready low before completion
        logic        slverr;
        logic [31:0] prdata;
        int          hold;      // cycles rsp_ready_i stays low in RESP
        logic        busy;      // busy_i level when the command is offered
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the response has been consumed.
    task automatic run_txn(input vec_t v);
        int          n;
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        exp_wd      = v.wr ? v.wdata : 32'h0;
        exp_st      = v.wr ? v.strb  : 4'h0;
        busy_i      = v.busy;
        cmd_write_i = v.wr;
        cmd_addr_i  = v.addr;
        cmd_wdata_i = v.wdata;
        cmd_strb_i  = v.strb;
        cmd_valid_i = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("accept_delay", n, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        // Busy rising mid-transfer must not disturb it.
        busy_i = 1'b1;
        chk("setup_psel", psel_o, 1);
        chk("setup_penable", penable_o, 0);
        chk("setup_paddr", paddr_o, v.addr);
        chk("setup_pwrite", pwrite_o, v.wr);
        chk("setup_pwdata", pwdata_o, exp_wd);
        chk("setup_pstrb", pstrb_o, exp_st);
        chk("setup_cmd_ready", cmd_ready_o, 0);
        for (int w = 0; w <= v.waits; w++) begin
            @(negedge clk_i);
            chk("access_psel", psel_o, 1);
            chk("access_penable", penable_o, 1);
            chk("access_rsp_valid", rsp_valid_o, 0);
            chk("access_pwdata", pwdata_o, exp_wd);
            chk("access_pstrb", pstrb_o, exp_st);
            chk("access_paddr", paddr_o, v.addr);
            pready_i  = (w == v.waits);
            pslverr_i = (w == v.waits) ? v.slverr : 1'b0;
            prdata_i  = (w == v.waits) ? v.prdata : 32'hCAFE_0000;
        end
        @(negedge clk_i);
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        prdata_i  = ~v.prdata;
        chk("resp_valid", rsp_valid_o, 1);
        chk("resp_psel", psel_o, 0);
        chk("resp_penable", penable_o, 0);
        chk("resp_rdata", rsp_rdata_o, v.exp_rdata);
        chk("resp_err", rsp_err_o, v.exp_err);
        chk("resp_timeout", rsp_timeout_o, 0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk_i);
            chk("hold_valid", rsp_valid_o, 1);
            chk("hold_rdata", rsp_rdata_o, v.exp_rdata);
            chk("hold_err", rsp_err_o, v.exp_err);
            chk("hold_psel", psel_o, 0);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        busy_i      = 1'b0;
        chk("resp_done", rsp_valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        vec_t rd0;
        vec_t wb;
        vecs[0] = '{1'b1, 16'h0010, 32'hA5A5_0F0F, 4'hF, 0, 1'b0, 32'h9999_9999, 0, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 16'h0020, 32'hFFFF_FFFF, 4'hF, 2, 1'b0, 32'h1234_5678, 0, 1'b0, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 16'h0030, 32'h1122_3344, 4'h5, 1, 1'b1, 32'h5555_AAAA, 0, 1'b0, 32'h0, 1'b1};
        vecs[3] = '{1'b0, 16'h0004, 32'h0, 4'h3, 0, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 1'b1};
        // pready arrives in the would-be abort cycle: completion wins.
        vecs[4] = '{1'b1, 16'h0044, 32'h0BAD_F00D, 4'h9, 3, 1'b0, 32'h7777_7777, 0, 1'b0, 32'h0, 1'b0};
        // Read while busy, response stalled three cycles.
        vecs[5] = '{1'b0, 16'h0000, 32'h0, 4'h0, 0, 1'b0, 32'h0000_00C3, 3, 1'b1, 32'h0000_00C3, 1'b0};
        rd0 = '{1'b0, 16'h0008, 32'h0, 4'h0, 1, 1'b0, 32'h8765_4321, 0, 1'b0, 32'h8765_4321, 1'b0};
        wb  = '{1'b1, 16'h0040, 32'h0102_0304, 4'hC, 0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0};

        rst_i       = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 16'h0;
        cmd_wdata_i = 32'h0;
        cmd_strb_i  = 4'h0;
        rsp_ready_i = 1'b0;
        pready_i    = 1'b0;
        pslverr_i   = 1'b0;
        prdata_i    = 32'h0;
        busy_i      = 1'b0;

        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_cmd_ready", cmd_ready_o, 0);
        chk("rst_psel", psel_o, 0);
        chk("rst_penable", penable_o, 0);
        chk("rst_pwrite", pwrite_o, 0);
        chk("rst_paddr", paddr_o, 0);
        chk("rst_pwdata", pwdata_o, 0);
        chk("rst_pstrb", pstrb_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_rdata", rsp_rdata_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_rsp_timeout", rsp_timeout_o, 0);
        cmd_valid_i = 1'b0;
        rst_i       = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i]);
        end

        // Write held off while busy; nothing starts on the bus.
        busy_i      = 1'b1;
        cmd_write_i = 1'b1;
        cmd_addr_i  = wb.addr;
        cmd_wdata_i = wb.wdata;
        cmd_strb_i  = wb.strb;
        cmd_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("busy_block_ready", cmd_ready_o, 0);
            @(negedge clk_i);
            chk("busy_block_psel", psel_o, 0);
        end
        run_txn(wb);

        // Timeout: pready never rises, abort on the 4th ACCESS edge.
        cmd_write_i = 1'b0;
        cmd_addr_i  = 16'h0050;
        cmd_valid_i = 1'b1;
        prdata_i    = 32'hFFFF_FFFF;
        #1;
        chk("to_ready", cmd_ready_o, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        chk("to_setup_psel", psel_o, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            chk("to_wait_penable", penable_o, 1);
            chk("to_wait_rsp_valid", rsp_valid_o, 0);
        end
        @(negedge clk_i);
        chk("to_psel", psel_o, 0);
        chk("to_penable", penable_o, 0);
        chk("to_rsp_valid", rsp_valid_o, 1);
        chk("to_rsp_err", rsp_err_o, 1);
        chk("to_rsp_timeout", rsp_timeout_o, 1);
        chk("to_rsp_rdata", rsp_rdata_o, 0);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk("to_done", rsp_valid_o, 0);

        // Reset pulsed in ACCESS discards the transfer.
        cmd_write_i = 1'b1;
        cmd_addr_i  = 16'h0060;
        cmd_wdata_i = 32'hAAAA_5555;
        cmd_strb_i  = 4'hF;
        cmd_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        chk("mid_access_penable", penable_o, 1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("mid_rst_psel", psel_o, 0);
        chk("mid_rst_penable", penable_o, 0);
        chk("mid_rst_pwrite", pwrite_o, 0);
        chk("mid_rst_paddr", paddr_o, 0);
        chk("mid_rst_pwdata", pwdata_o, 0);
        chk("mid_rst_pstrb", pstrb_o, 0);
        chk("mid_rst_rsp_valid", rsp_valid_o, 0);
        chk("mid_rst_cmd_ready", cmd_ready_o, 0);
        @(negedge clk_i);
        rst_i    = 1'b0;
        pready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            chk("post_rst_rsp_valid", rsp_valid_o, 0);
            chk("post_rst_psel", psel_o, 0);
        end
        pready_i = 1'b0;
        run_txn(rd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
